// File: rtl/cla_restoring_divider_pkg.sv
// Shared constants and FSM state type for the iterative CLA restoring divider.
package cla_restoring_divider_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int SLICE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_restoring_divider_cla_subtractor.sv
// N-bit subtractor a - b built as a chain of 4-bit carry-look-ahead slices
// computing a + ~b + 1; no_borrow is the final carry-out (1 when a >= b).
module cla_subtractor
  import cla_restoring_divider_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  localparam int NS = (N + SLICE_W - 1) / SLICE_W;
  localparam int NP = NS * SLICE_W;

  // Zero-extending both operands keeps the carry-out equal to a >= b.
  logic [NP-1:0] a_pad;
  logic [NP-1:0] b_inv;
  logic [NS:0]   carry;

  assign a_pad    = NP'(a);
  assign b_inv    = ~(NP'(b));
  assign carry[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a_pad[s*SLICE_W +: SLICE_W] & b_inv[s*SLICE_W +: SLICE_W];
    assign p    = a_pad[s*SLICE_W +: SLICE_W] ^ b_inv[s*SLICE_W +: SLICE_W];
    assign c[0] = carry[s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign carry[s+1] = c[4];

    // Padding bits only feed the carry chain; their sums are not produced.
    for (genvar k = 0; k < SLICE_W; k++) begin : g_bit
      if (s * SLICE_W + k < N) begin : g_out
        assign diff[s*SLICE_W + k] = p[k] ^ c[k];
      end
    end
  end

  assign no_borrow = carry[NS];

endmodule

// File: rtl/cla_restoring_divider.sv
// Iterative unsigned restoring divider: one shift-and-trial-subtract per cycle,
// quotient bits resolved MSB first, results held from done until the next start.
module cla_restoring_divider
  import cla_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;

  // The restored remainder is always below the divisor, so rem_q[WIDTH]
  // stays zero and only the low WIDTH bits shift up.
  assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a         (rem_shift),
    .b         ({1'b0, div_q}),
    .diff      (trial),
    .no_borrow (no_borrow)
  );

  assign rem_d = no_borrow ? trial : rem_shift;
  assign quo_d = {quo_q[WIDTH-2:0], no_borrow};

  // NOTE: every state register is updated with <= so all of them see the
  // pre-edge values of each other; blocking = here would chain the updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q     <= ST_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              quo_q   <= dividend;
              div_q   <= divisor;
              rem_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        ST_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= quo_d;
            remainder_q <= rem_d[WIDTH-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cla_restoring_divider.sv
// Directed and randomized checks of cla_restoring_divider with WIDTH=16:
// results, latency, hold behaviour, ignored starts and reset abort.
module tb_cla_restoring_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Present a start for exactly one edge, then scramble the data inputs.
  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // lat counts edges with the start-sampling edge as 1; bounded at 64.
  task automatic wait_done(input int lat0, output int lat, output int busy_cycles);
    lat         = lat0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero});
    end
    total++;
    if (quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL reset_data got q=%0h r=%0h want q=0 r=0", quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(16'd100, 16'd7);
    wait_done(1, lat, bc);
    total++;
    if (lat !== 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
    total++;
    if (bc !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bc); end
    total++;
    if (quotient !== 16'd14 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL basic_result got q=%0d r=%0d z=%b want q=14 r=2 z=0",
                      quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      bad++; $display("FAIL basic_hold got q=%0d r=%0d want q=14 r=2", quotient, remainder);
    end
  endtask

  task automatic test_extremes();
    int lat, bc;
    issue(16'hFFFF, 16'd1);
    wait_done(1, lat, bc);
    total++;
    if (lat !== 17 || quotient !== 16'hFFFF || remainder !== 16'd0) begin
      bad++; $display("FAIL max_by_one got lat=%0d q=%0h r=%0h want lat=17 q=ffff r=0",
                      lat, quotient, remainder);
    end
    issue(16'hFFFF, 16'hFFFF);
    wait_done(1, lat, bc);
    total++;
    if (lat !== 17 || quotient !== 16'd1 || remainder !== 16'd0) begin
      bad++; $display("FAIL max_by_max got lat=%0d q=%0h r=%0h want lat=17 q=1 r=0",
                      lat, quotient, remainder);
    end
  endtask

  task automatic test_small_and_zero();
    int lat, bc;
    issue(16'd3, 16'd10);
    wait_done(1, lat, bc);
    total++;
    if (quotient !== 16'd0 || remainder !== 16'd3 || div_by_zero !== 1'b0) begin
      bad++; $display("FAIL divisor_gt_dividend got q=%0d r=%0d z=%b want q=0 r=3 z=0",
                      quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    issue(16'd5, 16'd0);
    wait_done(1, lat, bc);
    total++;
    if (lat !== 1 || busy !== 1'b0) begin
      bad++; $display("FAIL dbz_latency got lat=%0d busy=%b want lat=1 busy=0", lat, busy);
    end
    total++;
    if (quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_result got q=%0h r=%0d z=%b want q=ffff r=5 z=1",
                      quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_after got done=%b z=%b want done=0 z=1", done, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(16'd100, 16'd7);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, lat, bc);
    total++;
    if (lat !== 17 || quotient !== 16'd14 || remainder !== 16'd2) begin
      bad++; $display("FAIL ignored_start got lat=%0d q=%0d r=%0d want lat=17 q=14 r=2",
                      lat, quotient, remainder);
    end
    issue(16'd50, 16'd5);
    total++;
    if (busy !== 1'b1 || quotient !== 16'd14) begin
      bad++; $display("FAIL b2b_accept got busy=%b q=%0d want busy=1 q=14", busy, quotient);
    end
    wait_done(1, lat, bc);
    total++;
    if (lat !== 17 || quotient !== 16'd10 || remainder !== 16'd0) begin
      bad++; $display("FAIL b2b_result got lat=%0d q=%0d r=%0d want lat=17 q=10 r=0",
                      lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, pulses;
    issue(16'd1000, 16'd3);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      bad++; $display("FAIL abort_clear got busy=%b done=%b z=%b q=%0d r=%0d want all 0",
                      busy, done, div_by_zero, quotient, remainder);
    end
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", pulses); end
    issue(16'd1000, 16'd3);
    wait_done(1, lat, bc);
    total++;
    if (lat !== 17 || quotient !== 16'd333 || remainder !== 16'd1) begin
      bad++; $display("FAIL abort_rerun got lat=%0d q=%0d r=%0d want lat=17 q=333 r=1",
                      lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] dvd, dvs, exp_q, exp_r;
    int exp_lat;
    logic exp_z;
    for (int i = 0; i < 2000; i++) begin
      dvd = W'($urandom);
      case ($urandom_range(0, 5))
        0:       dvs = '0;
        1:       dvs = W'($urandom_range(1, 15));
        2:       dvs = W'($urandom_range(1, 255));
        3:       dvs = (dvd == 16'hFFFF) ? dvd : dvd + W'($urandom_range(1, 16'hFFFF - dvd));
        default: dvs = W'($urandom);
      endcase
      if (dvs == '0) begin
        exp_q = 16'hFFFF; exp_r = dvd; exp_z = 1'b1; exp_lat = 1;
      end else begin
        exp_q = dvd / dvs; exp_r = dvd % dvs; exp_z = 1'b0; exp_lat = 17;
      end
      issue(dvd, dvs);
      wait_done(1, lat, bc);
      total++;
      if (lat !== exp_lat || quotient !== exp_q || remainder !== exp_r || div_by_zero !== exp_z) begin
        bad++; $display("FAIL rand_%0d %0d/%0d got lat=%0d q=%0d r=%0d z=%b want lat=%0d q=%0d r=%0d z=%b",
                        i, dvd, dvs, lat, quotient, remainder, div_by_zero,
                        exp_lat, exp_q, exp_r, exp_z);
      end
      if (dvs != '0) begin
        total++;
        if (32'(quotient) * 32'(dvs) + 32'(remainder) !== 32'(dvd) || remainder >= dvs) begin
          bad++; $display("FAIL rand_invariant_%0d %0d/%0d got q=%0d r=%0d", i, dvd, dvs,
                          quotient, remainder);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_small_and_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
